// File: rtl/spb_rx_frame_ctrl.sv
// Receive-frame sequencer for the SD/PD/BD detection chain (32.768 MHz domain).
// Define SPB_RX_FRAME_STATS_EN to add the saturating frame/abort statistics counters.
module spb_rx_frame_ctrl #(
    parameter int LEN_W = 12,
    parameter int TO_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_32M768_n,
    input  logic             ctrl_en,
    input  logic             sym_strobe,
    input  logic             SD_flag,
    input  logic             PD_flag,
    input  logic             BD_flag,
    input  logic             BD_sgn,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [TO_W-1:0]  bd_timeout,
    input  logic [TO_W-1:0]  holdoff_syms,
    output logic             disassert_PD,
    output logic             disassert_BD,
    output logic             payload_en,
    output logic             phase_invert,
    output logic             frame_done,
    output logic             frame_err,
    output logic [2:0]       rx_state
`ifdef SPB_RX_FRAME_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_bd_timeouts,
    output logic [CNT_W-1:0] stat_sd_losses
`endif
);

    // One shared symbol counter serves the BD timeout, payload and holdoff phases.
    localparam int SC_W = (LEN_W > TO_W) ? LEN_W : TO_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_BD = 3'd1,
        PAYLOAD = 3'd2,
        HOLDOFF = 3'd3
    } state_t;

    state_t           state_q;
    logic [SC_W-1:0]  cnt_q;
    logic [SC_W-1:0]  cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             dis_pd_q;
    logic             dis_bd_q;
    logic             pay_q;
    logic             phase_q;
    logic             done_q;
    logic             err_q;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (&v) ? v : v + SC_W'(1);
    endfunction

    assign cnt_d = sat_inc(cnt_q);

    always_ff @(posedge clk or negedge rst_32M768_n) begin
        if (!rst_32M768_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            dis_pd_q <= 1'b0;
            dis_bd_q <= 1'b1;
            pay_q    <= 1'b0;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pay_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (!ctrl_en) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                dis_pd_q <= 1'b0;
                dis_bd_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (PD_flag && SD_flag) begin
                            state_q  <= WAIT_BD;
                            cnt_q    <= '0;
                            dis_bd_q <= 1'b0;
                        end
                    end
                    WAIT_BD: begin
                        // A Barker hit outranks both the timeout and a signal loss.
                        if (BD_flag) begin
                            state_q  <= PAYLOAD;
                            phase_q  <= BD_sgn;
                            len_q    <= frame_len;
                            cnt_q    <= '0;
                            dis_pd_q <= 1'b1;
                            dis_bd_q <= 1'b1;
                        end else if (!SD_flag ||
                                     (sym_strobe && cnt_d >= SC_W'(bd_timeout))) begin
                            state_q  <= HOLDOFF;
                            cnt_q    <= '0;
                            err_q    <= 1'b1;
                            dis_pd_q <= 1'b1;
                            dis_bd_q <= 1'b1;
                        end else if (sym_strobe) begin
                            cnt_q <= cnt_d;
                        end
                    end
                    PAYLOAD: begin
                        if (len_q == '0) begin
                            state_q <= HOLDOFF;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else if (sym_strobe && cnt_d == SC_W'(len_q)) begin
                            state_q <= HOLDOFF;
                            cnt_q   <= '0;
                            pay_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (!SD_flag) begin
                            state_q <= HOLDOFF;
                            cnt_q   <= '0;
                            err_q   <= 1'b1;
                        end else if (sym_strobe) begin
                            pay_q <= 1'b1;
                            cnt_q <= cnt_d;
                        end
                    end
                    HOLDOFF: begin
                        if (holdoff_syms == '0 ||
                            (sym_strobe && cnt_d >= SC_W'(holdoff_syms))) begin
                            state_q  <= IDLE;
                            cnt_q    <= '0;
                            dis_pd_q <= 1'b0;
                            dis_bd_q <= 1'b1;
                        end else if (sym_strobe) begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        dis_pd_q <= 1'b0;
                        dis_bd_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign disassert_PD = dis_pd_q;
    assign disassert_BD = dis_bd_q;
    assign payload_en   = pay_q;
    assign phase_invert = phase_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign rx_state     = state_q;

`ifdef SPB_RX_FRAME_STATS_EN
    // Abort cause: a timeout needs SD high when sampled, a signal loss has SD low.
    logic             sd_prev_q;
    logic [CNT_W-1:0] frames_q;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] sdl_q;

    function automatic logic [CNT_W-1:0] sat_stat(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_32M768_n) begin
        if (!rst_32M768_n) begin
            sd_prev_q <= 1'b0;
            frames_q  <= '0;
            tmo_q     <= '0;
            sdl_q     <= '0;
        end else begin
            sd_prev_q <= SD_flag;
            if (stat_clr) begin
                frames_q <= '0;
                tmo_q    <= '0;
                sdl_q    <= '0;
            end else begin
                if (done_q)               frames_q <= sat_stat(frames_q);
                if (err_q && sd_prev_q)   tmo_q    <= sat_stat(tmo_q);
                if (err_q && !sd_prev_q)  sdl_q    <= sat_stat(sdl_q);
            end
        end
    end

    assign stat_frames      = frames_q;
    assign stat_bd_timeouts = tmo_q;
    assign stat_sd_losses   = sdl_q;
`endif

endmodule

// File: tb/tb_spb_rx_frame_ctrl.sv
// Directed and randomized checks of spb_rx_frame_ctrl against a frame-level model.
`timescale 1ns/1ps
module tb_spb_rx_frame_ctrl;
    localparam int LEN_W = 12;
    localparam int TO_W  = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ctrl_en;
    logic             sym_strobe;
    logic             SD;
    logic             PD;
    logic             BD;
    logic             sgn;
    logic [LEN_W-1:0] frame_len;
    logic [TO_W-1:0]  bd_timeout;
    logic [TO_W-1:0]  holdoff;
    logic             dis_pd;
    logic             dis_bd;
    logic             payload_en;
    logic             phase_invert;
    logic             frame_done;
    logic             frame_err;
    logic [2:0]       rx_state;
`ifdef SPB_RX_FRAME_STATS_EN
    logic             stat_clr;
    logic [CNT_W-1:0] stat_frames;
    logic [CNT_W-1:0] stat_bd_timeouts;
    logic [CNT_W-1:0] stat_sd_losses;
`endif

    spb_rx_frame_ctrl #(.LEN_W(LEN_W), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_32M768_n (rst_n),
        .ctrl_en      (ctrl_en),
        .sym_strobe   (sym_strobe),
        .SD_flag      (SD),
        .PD_flag      (PD),
        .BD_flag      (BD),
        .BD_sgn       (sgn),
        .frame_len    (frame_len),
        .bd_timeout   (bd_timeout),
        .holdoff_syms (holdoff),
        .disassert_PD (dis_pd),
        .disassert_BD (dis_bd),
        .payload_en   (payload_en),
        .phase_invert (phase_invert),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .rx_state     (rx_state)
`ifdef SPB_RX_FRAME_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_frames      (stat_frames),
        .stat_bd_timeouts (stat_bd_timeouts),
        .stat_sd_losses   (stat_sd_losses)
`endif
    );

    always #15 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_pay  = 0;
    int n_done = 0;
    int n_err  = 0;
    int p0, d0, e0;

    // Pulse tallies sampled mid-cycle; scenarios compare differences.
    always @(negedge clk) begin
        if (payload_en === 1'b1) n_pay++;
        if (frame_done === 1'b1) n_done++;
        if (frame_err  === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            sym_strobe = 1'b1;
            tick();
            sym_strobe = 1'b0;
            tick();
        end
    endtask

    task automatic enter();
        PD = 1'b1;
        tick();
        PD = 1'b0;
    endtask

    task automatic bd_hit(input logic s, input int len);
        BD        = 1'b1;
        sgn       = s;
        frame_len = LEN_W'(len);
        tick();
        BD  = 1'b0;
        sgn = 1'b0;
    endtask

    task automatic snap();
        p0 = n_pay;
        d0 = n_done;
        e0 = n_err;
    endtask

    initial begin
        int model_phase;
        rst_n = 1'b1; ctrl_en = 1'b1; sym_strobe = 1'b0; SD = 1'b0; PD = 1'b0;
        BD = 1'b0; sgn = 1'b0; frame_len = 8; bd_timeout = 100; holdoff = 4;
`ifdef SPB_RX_FRAME_STATS_EN
        stat_clr = 1'b0;
`endif
        #5 rst_n = 1'b0;
        #1;
        check("rst_state", rx_state, 0);
        check("rst_dis_pd", dis_pd, 0);
        check("rst_dis_bd", dis_bd, 1);
        check("rst_payload_en", payload_en, 0);
        check("rst_phase", phase_invert, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Nominal frame
        SD = 1'b1;
        enter();
        check("nom_wait_state", rx_state, 1);
        check("nom_wait_dis_bd", dis_bd, 0);
        check("nom_wait_dis_pd", dis_pd, 0);
        strobes(5);
        check("nom_wait_hold", rx_state, 1);
        bd_hit(1'b1, 8);
        check("nom_pay_state", rx_state, 2);
        check("nom_phase", phase_invert, 1);
        check("nom_pay_dis_pd", dis_pd, 1);
        check("nom_pay_dis_bd", dis_bd, 1);
        snap();
        strobes(7);
        check("nom_pay7", n_pay - p0, 7);
        check("nom_done_early", n_done - d0, 0);
        strobes(1);
        check("nom_pay8", n_pay - p0, 8);
        check("nom_done", n_done - d0, 1);
        check("nom_err", n_err - e0, 0);
        check("nom_hold_state", rx_state, 3);
        check("nom_hold_dis_pd", dis_pd, 1);
        strobes(3);
        check("nom_hold3", rx_state, 3);
        strobes(1);
        check("nom_idle", rx_state, 0);
        check("nom_idle_dis_pd", dis_pd, 0);
        check("nom_idle_dis_bd", dis_bd, 1);
        check("nom_phase_hold", phase_invert, 1);

        // BD timeout
        bd_timeout = 20;
        enter();
        snap();
        strobes(19);
        check("tmo_19_err", n_err - e0, 0);
        check("tmo_19_state", rx_state, 1);
        strobes(1);
        check("tmo_err", n_err - e0, 1);
        check("tmo_state", rx_state, 3);
        check("tmo_dis_pd", dis_pd, 1);
        check("tmo_dis_bd", dis_bd, 1);
        strobes(4);
        check("tmo_idle", rx_state, 0);
        bd_timeout = 100;

        // SD loss mid-payload
        enter();
        bd_hit(1'b0, 100);
        check("sdl_phase", phase_invert, 0);
        snap();
        strobes(30);
        SD = 1'b0; tick(); SD = 1'b1; tick();
        check("sdl_pay", n_pay - p0, 30);
        check("sdl_err", n_err - e0, 1);
        check("sdl_done", n_done - d0, 0);
        check("sdl_state", rx_state, 3);
        strobes(4);

        // Final strobe collides with SD drop
        enter();
        bd_hit(1'b0, 3);
        snap();
        strobes(2);
        SD = 1'b0; sym_strobe = 1'b1; tick();
        SD = 1'b1; sym_strobe = 1'b0; tick();
        check("col_pay", n_pay - p0, 3);
        check("col_done", n_done - d0, 1);
        check("col_err", n_err - e0, 0);
        check("col_state", rx_state, 3);
        strobes(4);

        // BD_flag on the timeout strobe
        bd_timeout = 5;
        enter();
        snap();
        strobes(4);
        BD = 1'b1; frame_len = 2; sym_strobe = 1'b1; tick();
        BD = 1'b0; sym_strobe = 1'b0; tick();
        check("bdt_state", rx_state, 2);
        check("bdt_err", n_err - e0, 0);
        strobes(2);
        check("bdt_done", n_done - d0, 1);
        check("bdt_hold", rx_state, 3);
        strobes(4);
        bd_timeout = 100;

        // frame_len=0 and holdoff_syms=0
        holdoff = 0;
        enter();
        snap();
        bd_hit(1'b1, 0);
        check("len0_state", rx_state, 2);
        check("len0_done_pre", frame_done, 0);
        tick();
        check("len0_done", frame_done, 1);
        check("len0_pay_pulse", payload_en, 0);
        check("len0_hold", rx_state, 3);
        tick();
        check("hold0_idle", rx_state, 0);
        check("len0_pay", n_pay - p0, 0);
        check("len0_done_cnt", n_done - d0, 1);
        holdoff = 4;

        // Asynchronous reset mid-payload
        enter();
        bd_hit(1'b1, 50);
        strobes(2);
        snap();
        sym_strobe = 1'b1; tick(); sym_strobe = 1'b0;
        check("rstm_pay_high", payload_en, 1);
        rst_n = 1'b0;
        #1;
        check("rstm_state", rx_state, 0);
        check("rstm_pay", payload_en, 0);
        check("rstm_phase", phase_invert, 0);
        check("rstm_dis_pd", dis_pd, 0);
        check("rstm_dis_bd", dis_bd, 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstm_done", n_done - d0, 0);
        check("rstm_err", n_err - e0, 0);

        // ctrl_en drop mid-WAIT_BD
        enter();
        strobes(2);
        snap();
        ctrl_en = 1'b0;
        tick();
        check("en_state", rx_state, 0);
        check("en_dis_pd", dis_pd, 0);
        check("en_dis_bd", dis_bd, 1);
        ctrl_en = 1'b1;
        tick();
        tick();
        check("en_err", n_err - e0, 0);
        check("en_done", n_done - d0, 0);
        check("en_idle", rx_state, 0);

        // Randomized frames against a frame-level outcome model
        model_phase = 0;
        for (int f = 0; f < 30; f++) begin
            int kind, len, h, s, k, d, tmo, exp_pay, exp_done, exp_err;
            kind = $urandom_range(2, 0);
            len  = $urandom_range(12, 0);
            h    = $urandom_range(3, 0);
            s    = $urandom_range(1, 0);
            if (kind == 2 && len < 2) kind = 0;
            holdoff = TO_W'(h);
            snap();
            enter();
            if (kind == 1) begin
                tmo = $urandom_range(8, 1);
                bd_timeout = TO_W'(tmo);
                strobes(tmo);
                exp_pay = 0; exp_done = 0; exp_err = 1;
            end else begin
                bd_timeout = 8;
                d = $urandom_range(7, 0);
                strobes(d);
                bd_hit(s[0], len);
                model_phase = s;
                if (kind == 0) begin
                    if (len == 0) begin
                        tick(); tick();
                    end else begin
                        strobes(len);
                    end
                    exp_pay = len; exp_done = 1; exp_err = 0;
                end else begin
                    k = $urandom_range(len - 1, 0);
                    strobes(k);
                    SD = 1'b0; tick(); SD = 1'b1; tick();
                    exp_pay = k; exp_done = 0; exp_err = 1;
                end
            end
            if (h > 0) strobes(h);
            check("rnd_pay", n_pay - p0, exp_pay);
            check("rnd_done", n_done - d0, exp_done);
            check("rnd_err", n_err - e0, exp_err);
            check("rnd_phase", phase_invert, model_phase);
            check("rnd_idle", rx_state, 0);
        end

`ifdef SPB_RX_FRAME_STATS_EN
        stat_clr = 1'b1; tick(); stat_clr = 1'b0; tick();
        check("st_clr0_frames", stat_frames, 0);
        holdoff = 0; bd_timeout = 8;
        for (int i = 0; i < 3; i++) begin
            enter();
            bd_hit(1'b0, 1);
            strobes(1);
        end
        bd_timeout = 3;
        enter();
        strobes(3);
        enter();
        SD = 1'b0; tick(); SD = 1'b1; tick();
        check("st_frames", stat_frames, 3);
        check("st_tmo", stat_bd_timeouts, 1);
        check("st_sdl", stat_sd_losses, 1);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("st_clr_frames", stat_frames, 0);
        check("st_clr_tmo", stat_bd_timeouts, 0);
        check("st_clr_sdl", stat_sd_losses, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spb_rx_frame_ctrl.md
Name: spb_rx_frame_ctrl

Overview:
- Receive-frame sequencer for the signal/preamble/Barker detection chain, in the 32.768 MHz domain.
- Consumes SD_flag, PD_flag, BD_flag and BD_sgn, and drives disassert_PD and disassert_BD back into the detectors.
- Frames the payload: gates payload symbols, latches the BPSK phase-ambiguity sign, and enforces timeouts and a re-arm holdoff.
- Sits between the detection chain and the demod/deframer.

Parameters:
- LEN_W, 12, width of the frame_len payload-symbol count.
- TO_W, 10, width of the BD timeout and holdoff symbol counts.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  32.768 MHz system clock.
- rst_32M768_n  in  1  asynchronous active-low reset.
- ctrl_en  in  1  controller enable; 0 forces IDLE.
- sym_strobe  in  1  one-clk pulse per received symbol (1 MHz); all symbol counters advance only on it.
- SD_flag  in  1  signal-detect flag.
- PD_flag  in  1  preamble-detect flag.
- BD_flag  in  1  Barker-detect flag.
- BD_sgn  in  1  Barker correlation sign; 1 = inverted phase.
- frame_len  in  LEN_W  payload length in symbols; latched on BD hit.
- bd_timeout  in  TO_W  maximum symbols allowed in WAIT_BD.
- holdoff_syms  in  TO_W  symbols to hold the detectors cleared after a frame.
- disassert_PD  out  1  clears the PD detector while high.
- disassert_BD  out  1  clears the BD detector while high.
- payload_en  out  1  one-clk pulse, coincident with sym_strobe, for each payload symbol.
- phase_invert  out  1  latched BD_sgn for the current frame.
- frame_done  out  1  one-clk pulse when a frame completes.
- frame_err  out  1  one-clk pulse on abort.
- rx_state  out  3  current state encoding.

Behaviour:
- Reset values: state IDLE; disassert_PD=0, disassert_BD=1, payload_en=0, phase_invert=0, frame_done=0, frame_err=0; all counters 0.
- All outputs are registered. A state change takes effect one clk after the qualifying input is sampled.
- State encoding: IDLE=0, WAIT_BD=1, PAYLOAD=2, HOLDOFF=3.
- IDLE: disassert_PD=0, disassert_BD=1. When PD_flag=1 and SD_flag=1, go to WAIT_BD and clear the symbol counter.
- WAIT_BD: disassert_BD=0.
  - BD_flag=1: go to PAYLOAD; latch phase_invert<=BD_sgn and len<=frame_len; clear the counter.
  - Otherwise, the counter increments on each sym_strobe. When the counter equals bd_timeout on a strobe, pulse frame_err and go to HOLDOFF.
  - SD_flag=0: pulse frame_err and go to HOLDOFF.
  - BD_flag and timeout on the same clk: BD_flag wins.
- PAYLOAD: disassert_PD=1, disassert_BD=1 (detectors frozen during the payload).
  - Each sym_strobe: payload_en=1 and the counter increments.
  - On the strobe where counter+1==len: pulse frame_done and go to HOLDOFF.
  - len==0: pulse frame_done on the first clk in PAYLOAD, with no payload_en pulses.
  - SD_flag=0 without a final strobe: pulse frame_err and go to HOLDOFF.
  - Final strobe and SD drop on the same clk: frame_done wins, no frame_err.
- HOLDOFF: both disassert outputs are 1. Count holdoff_syms strobes, then go to IDLE. holdoff_syms==0 returns to IDLE on the next clk.
- phase_invert holds its value until the next BD hit. Reset clears it.
- ctrl_en=0: on the next clk, force IDLE outputs and clear counters. No done/err pulse.
- Asynchronous reset mid-frame: immediate return to reset values. No pulses.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: SPB_RX_FRAME_STATS_EN.
- When defined, add three outputs, each CNT_W wide and saturating at all-ones: stat_frames (frame_done count), stat_bd_timeouts and stat_sd_losses (abort causes).
- Add input stat_clr (1 bit), which synchronously zeroes all three counters. If stat_clr and an event occur on the same clk, the clear wins.
- When the macro is undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Nominal frame: SD=1, PD pulse, BD_flag with BD_sgn=1 after 5 strobes, frame_len=8, holdoff_syms=4 -> WAIT_BD, then PAYLOAD with phase_invert=1; exactly 8 payload_en pulses; frame_done on the 8th; IDLE after 4 further strobes.
- BD timeout: bd_timeout=20, no BD_flag -> frame_err on the 20th strobe; HOLDOFF with both disassert high.
- SD loss mid-payload: frame_len=100, SD_flag drops after 30 payload strobes -> exactly 30 payload_en pulses, frame_err=1, no frame_done.
- Collisions: final payload strobe together with SD drop -> frame_done only; BD_flag on the same strobe as timeout -> PAYLOAD entered, no frame_err.
- Edge lengths: frame_len=0 -> frame_done one clk after BD with no payload_en; holdoff_syms=0 -> IDLE on the next clk.
- Reset/enable: assert rst_32M768_n low mid-PAYLOAD -> reset values immediately; ctrl_en=0 mid-WAIT_BD -> IDLE next clk with no pulses. With SPB_RX_FRAME_STATS_EN: 3 good frames and 1 timeout -> stat_frames=3, stat_bd_timeouts=1; stat_clr zeroes both.
